// File: rtl/score_pkg.sv
// Shared types and helpers for the score input front-end.
// Debouncer states and 2-bit value arithmetic.
package score_pkg;

  typedef enum logic [1:0] {
    S_RELEASED,
    S_PRESS_CHK,
    S_PRESSED,
    S_REL_CHK
  } deb_state_t;

  localparam int VAL_W = 2;
  localparam logic [VAL_W-1:0] VAL_MAX = 2'd3;

  function automatic logic [VAL_W-1:0] val_inc(
    input logic [VAL_W-1:0] v,
    input logic             sat
  );
    if (sat && v == VAL_MAX)
      return VAL_MAX;
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// One raw active-low button: 2-flop synchroniser, debounce FSM
// and a single-cycle press pulse per accepted press.
module btn_debouncer
  import score_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_ZERO = '0;

  logic       r_sync1;
  logic       r_sync2;
  logic       w_lvl;
  deb_state_t r_state;
  deb_state_t w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic       r_pulse;
  logic       w_pulse_nxt;

  assign w_lvl = r_sync2;

  // Bring the raw level into the clk domain; idle level is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state: a level change must hold long enough to be accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pulse_nxt = 1'b0;
    unique case (r_state)
      S_RELEASED: begin
        if (!w_lvl) begin
          w_state_nxt = S_PRESS_CHK;
          w_cnt_nxt   = C_ONE;
        end
      end
      S_PRESS_CHK: begin
        if (w_lvl) begin
          w_state_nxt = S_RELEASED;
          w_cnt_nxt   = C_ZERO;
        end else if (r_cnt == C_MAX) begin
          w_state_nxt = S_PRESSED;
          w_cnt_nxt   = C_ZERO;
          w_pulse_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      S_PRESSED: begin
        if (w_lvl) begin
          w_state_nxt = S_REL_CHK;
          w_cnt_nxt   = C_ONE;
        end
      end
      S_REL_CHK: begin
        if (!w_lvl) begin
          w_state_nxt = S_PRESSED;
          w_cnt_nxt   = C_ZERO;
        end else if (r_cnt == C_MAX) begin
          w_state_nxt = S_RELEASED;
          w_cnt_nxt   = C_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      default: begin
        w_state_nxt = S_RELEASED;
        w_cnt_nxt   = C_ZERO;
      end
    endcase
  end

  // Debounce state, counter and registered press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RELEASED;
      r_cnt   <= C_ZERO;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  assign o_press_pulse = r_pulse;

endmodule

// File: rtl/score_input_ctrl.sv
// Button front-end for the 7-segment decoder: two 2-bit values
// updated by debounced presses, plus a change pulse.
module score_input_ctrl
  import score_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit SATURATE        = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_inc1_n,
  input  logic             btn_inc2_n,
  input  logic             btn_clr_n,
  output logic [VAL_W-1:0] bin1,
  output logic [VAL_W-1:0] bin2,
  output logic             changed
);

  logic             w_inc1;
  logic             w_inc2;
  logic             w_clr;
  logic [VAL_W-1:0] r_bin1;
  logic [VAL_W-1:0] r_bin2;
  logic [VAL_W-1:0] w_nxt1;
  logic [VAL_W-1:0] w_nxt2;
  logic             w_diff;
  logic             r_diff;
  logic             r_changed;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_inc1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_btn_n      (btn_inc1_n),
    .o_press_pulse(w_inc1)
  );

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_inc2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_btn_n      (btn_inc2_n),
    .o_press_pulse(w_inc2)
  );

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_clr (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_btn_n      (btn_clr_n),
    .o_press_pulse(w_clr)
  );

  // Clear wins; otherwise both increments apply independently.
  always_comb begin
    w_nxt1 = r_bin1;
    w_nxt2 = r_bin2;
    if (w_clr) begin
      w_nxt1 = '0;
      w_nxt2 = '0;
    end else begin
      if (w_inc1)
        w_nxt1 = val_inc(r_bin1, SATURATE);
      if (w_inc2)
        w_nxt2 = val_inc(r_bin2, SATURATE);
    end
  end

  assign w_diff = (w_nxt1 != r_bin1) || (w_nxt2 != r_bin2);

  // Value registers; changed trails the actual update by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin1    <= '0;
      r_bin2    <= '0;
      r_diff    <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_bin1    <= w_nxt1;
      r_bin2    <= w_nxt2;
      r_diff    <= w_diff;
      r_changed <= r_diff;
    end
  end

  assign bin1    = r_bin1;
  assign bin2    = r_bin2;
  assign changed = r_changed;

endmodule

// File: tb/tb_score_input_ctrl.sv
// Bench for score_input_ctrl: wrap and saturate instances share
// stimulus and are checked every cycle against a run-length model.
module tb_score_input_ctrl;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic b1 = 1'b1;
  logic b2 = 1'b1;
  logic bc = 1'b1;

  logic [1:0] bin1_0, bin2_0, bin1_1, bin2_1;
  logic       chg_0, chg_1;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int chg_cnt0 = 0;
  int chg_cnt1 = 0;

  // model state: per button [inc1, inc2, clr], per instance [wrap, sat]
  int m_s1[3], m_s2[3], m_pressed[3], m_run[3], m_pulse[3];
  int m_bin1[2], m_bin2[2], m_diff[2], m_chg[2];

  always #5 clk = ~clk;

  score_input_ctrl #(.DEBOUNCE_CYCLES(D), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .btn_inc1_n(b1), .btn_inc2_n(b2), .btn_clr_n(bc),
    .bin1(bin1_0), .bin2(bin2_0), .changed(chg_0)
  );

  score_input_ctrl #(.DEBOUNCE_CYCLES(D), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .btn_inc1_n(b1), .btn_inc2_n(b2), .btn_clr_n(bc),
    .bin1(bin1_1), .bin2(bin2_1), .changed(chg_1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int inc(input int v, input int sat);
    if (sat != 0)
      return (v == 3) ? 3 : v + 1;
    return (v + 1) % 4;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_s1[b] = 1; m_s2[b] = 1;
      m_pressed[b] = 0; m_run[b] = 0; m_pulse[b] = 0;
    end
    for (int k = 0; k < 2; k++) begin
      m_bin1[k] = 0; m_bin2[k] = 0;
      m_diff[k] = 0; m_chg[k] = 0;
    end
  endtask

  // A level opposite to the accepted one must be seen D+1 times
  // in a row (two sync stages late) before it is accepted.
  task automatic model_step(input int r0, input int r1, input int r2);
    int raw[3];
    int n1, n2, lvl;
    raw[0] = r0; raw[1] = r1; raw[2] = r2;
    for (int k = 0; k < 2; k++) begin
      n1 = m_bin1[k];
      n2 = m_bin2[k];
      if (m_pulse[2] != 0) begin
        n1 = 0; n2 = 0;
      end else begin
        if (m_pulse[0] != 0) n1 = inc(n1, k);
        if (m_pulse[1] != 0) n2 = inc(n2, k);
      end
      m_chg[k] = m_diff[k];
      m_diff[k] = (n1 != m_bin1[k] || n2 != m_bin2[k]) ? 1 : 0;
      m_bin1[k] = n1;
      m_bin2[k] = n2;
    end
    for (int b = 0; b < 3; b++) begin
      lvl = m_s2[b];
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
      m_pulse[b] = 0;
      if (lvl == m_pressed[b]) m_run[b]++;
      else m_run[b] = 0;
      if (m_run[b] == D + 1) begin
        m_pulse[b] = 1 - m_pressed[b];
        m_pressed[b] = 1 - m_pressed[b];
        m_run[b] = 0;
      end
    end
  endtask

  initial model_reset();

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) model_reset();
    else model_step(int'(b1), int'(b2), int'(bc));
    #1;
    chk("bin1_wrap", int'(bin1_0), m_bin1[0]);
    chk("bin2_wrap", int'(bin2_0), m_bin2[0]);
    chk("chg_wrap", int'(chg_0), m_chg[0]);
    chk("bin1_sat", int'(bin1_1), m_bin1[1]);
    chk("bin2_sat", int'(bin2_1), m_bin2[1]);
    chk("chg_sat", int'(chg_1), m_chg[1]);
    if (chg_0) chg_cnt0++;
    if (chg_1) chg_cnt1++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mask bits: 0=inc1, 1=inc2, 2=clr
  task automatic press(input int mask);
    @(negedge clk);
    b1 = (mask & 1) ? 1'b0 : 1'b1;
    b2 = (mask & 2) ? 1'b0 : 1'b1;
    bc = (mask & 4) ? 1'b0 : 1'b1;
    idle(10);
    b1 = 1'b1; b2 = 1'b1; bc = 1'b1;
    idle(12);
  endtask

  int exp_w[5] = '{1, 2, 3, 0, 1};
  int exp_s[5] = '{1, 2, 3, 3, 3};
  int c0, c1;

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bin1", int'(bin1_0), 0);
    chk("rst_bin2", int'(bin2_0), 0);
    chk("rst_chg", int'(chg_0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // single held press: update 7 edges after first low sample
    c0 = chg_cnt0;
    b1 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("t1_before", int'(bin1_0), 0);
    @(posedge clk);
    #1;
    chk("t1_at7", int'(bin1_0), 1);
    chk("t1_chg_same", int'(chg_0), 0);
    @(posedge clk);
    #1;
    chk("t1_chg_next", int'(chg_0), 1);
    idle(10);
    b1 = 1'b1;
    idle(20);
    chk("t1_bin2", int'(bin2_0), 0);
    chk("t1_nchg", chg_cnt0 - c0, 1);

    // bounce: 2 low / 2 high for 16 cycles
    c0 = chg_cnt0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      b1 = (i % 4 < 2) ? 1'b0 : 1'b1;
    end
    b1 = 1'b1;
    idle(20);
    chk("t2_bin1", int'(bin1_0), 1);
    chk("t2_nchg", chg_cnt0 - c0, 0);

    // five presses on inc2: wrap vs saturate
    for (int p = 0; p < 5; p++) begin
      c1 = chg_cnt1;
      press(2);
      chk("t3_wrap", int'(bin2_0), exp_w[p]);
      chk("t3_sat", int'(bin2_1), exp_s[p]);
      chk("t3_satchg", chg_cnt1 - c1, (p < 3) ? 1 : 0);
    end

    // bin1=2, bin2=3, then clear with inc1 together
    press(1);
    press(2);
    press(2);
    chk("t4_pre1", int'(bin1_0), 2);
    chk("t4_pre2", int'(bin2_0), 3);
    c0 = chg_cnt0;
    press(5);
    chk("t4_bin1", int'(bin1_0), 0);
    chk("t4_bin2", int'(bin2_0), 0);
    chk("t4_nchg", chg_cnt0 - c0, 1);

    // simultaneous increments from 1/1
    press(3);
    c0 = chg_cnt0;
    press(3);
    chk("t5_bin1", int'(bin1_0), 2);
    chk("t5_bin2", int'(bin2_0), 2);
    chk("t5_nchg", chg_cnt0 - c0, 1);

    // reset in the middle of a held press
    @(negedge clk);
    b1 = 1'b0;
    idle(5);
    rst_n = 1'b0;
    idle(3);
    chk("t6_inrst", int'(bin1_0), 0);
    rst_n = 1'b1;
    c0 = chg_cnt0;
    repeat (7) @(posedge clk);
    #1;
    chk("t6_before", int'(bin1_0), 0);
    @(posedge clk);
    #1;
    chk("t6_at7", int'(bin1_0), 1);
    idle(20);
    b1 = 1'b1;
    idle(20);
    chk("t6_hold", int'(bin1_0), 1);
    chk("t6_nchg", chg_cnt0 - c0, 1);

    // random levels and hold times, occasional reset
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        idle(int'($urandom_range(1, 3)));
        rst_n = 1'b1;
      end
      b1 = 1'($urandom_range(0, 1));
      b2 = 1'($urandom_range(0, 1));
      bc = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
      idle(int'($urandom_range(1, 12)));
    end
    b1 = 1'b1; b2 = 1'b1; bc = 1'b1;
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_input_ctrl.md
Name: score_input_ctrl

Overview:
- Front-end stage that produces the two 2-bit binary values bin1/bin2 consumed directly by the Decoder (7-segment) stage.
- Takes three raw active-low pushbuttons (inc1, inc2, clear), synchronises and debounces each one, then turns every clean press into one update of a 2-bit value.
- Outputs are registered and stable between presses, so the downstream combinational Decoder sees glitch-free inputs.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable samples required to accept a level change (1 ms at 50 MHz); legal range >= 2.
- SATURATE, 0, 0 = value wraps 3 -> 0 on increment; 1 = value holds at 3.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn_inc1_n  input  1  raw button, active-low, asynchronous to clk; increments bin1
- btn_inc2_n  input  1  raw button, active-low, asynchronous to clk; increments bin2
- btn_clr_n  input  1  raw button, active-low; clears both values
- bin1  output  2  value to Decoder bin1
- bin2  output  2  value to Decoder bin2
- changed  output  1  one-cycle pulse in the cycle after bin1 or bin2 takes a new value

Behaviour:
- Reset is asynchronous assert, synchronous deassert. While rst_n=0: bin1=0, bin2=0, changed=0, all synchronisers=1 (released), all debouncers in S_RELEASED with count=0.
- Synchroniser: each button passes through a 2-flop synchroniser; "sampled level" means the second flop output.
- Debouncer FSM, one per button, four states:
  - S_RELEASED -> S_PRESS_CHK when the sampled level is 0; count=1.
  - S_PRESS_CHK: count increments while the level stays 0. If the level returns to 1, go back to S_RELEASED with count=0. When count reaches DEBOUNCE_CYCLES, go to S_PRESSED and assert press_pulse for exactly 1 cycle.
  - S_PRESSED -> S_REL_CHK when the level is 1; count=1.
  - S_REL_CHK: count increments while the level stays 1. If the level returns to 0, go back to S_PRESSED. When count reaches DEBOUNCE_CYCLES, go to S_RELEASED.
  - Holding a button produces exactly one pulse. No auto-repeat.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Latency:
  - A raw press held steady produces press_pulse DEBOUNCE_CYCLES+2 cycles after the first clk edge at which the raw level is 0.
  - bin updates on the edge after press_pulse.
  - changed is asserted in the cycle after that update.
- Value update rules, evaluated each cycle in priority order:
  1. clr pulse: bin1=0, bin2=0. A clear takes priority over any increment in the same cycle.
  2. Otherwise inc1 pulse: bin1 = bin1+1, modulo 4 if SATURATE=0, held at 3 if SATURATE=1.
  3. inc2 pulse: same rule applied to bin2, independently. Simultaneous inc1 and inc2 pulses both apply in the same cycle.
- changed rules:
  - changed=1 only if at least one value actually differs from its previous value.
  - Saturated increment at 3 gives no change and no pulse.
  - Clear when both values are already 0 gives no pulse.
- Bounce rejection: any glitch shorter than DEBOUNCE_CYCLES samples produces no pulse, in either the press or the release direction.
- Reset mid-press: all state returns to its reset values. A button still held after rst_n rises is debounced as a fresh press and counts once.

Decomposition:
- Shared package score_pkg holds:
  - typedef enum logic [1:0] deb_state_t {S_RELEASED, S_PRESS_CHK, S_PRESSED, S_REL_CHK};
  - localparam VAL_W=2 and VAL_MAX=2'd3.
- One sub-module, btn_debouncer (parameter DEBOUNCE_CYCLES), containing the synchroniser, FSM and counter, with a press_pulse output. It is instantiated three times.
- The top level holds only the value registers, the update priority logic and the changed pulse.

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
- Reset, then btn_inc1_n held low for 20 cycles and released for 20 cycles -> bin1 goes 0 -> 1 exactly 7 cycles after the first low sample; changed pulses once; bin2 stays 0.
- btn_inc1_n toggles low/high with 2-cycle periods for 16 cycles, then stays high -> no pulse; bin1 unchanged; changed never asserted.
- Five clean presses on btn_inc2_n with SATURATE=0 -> bin2 sequence 1, 2, 3, 0, 1. Repeat with SATURATE=1 -> 1, 2, 3, 3, 3, and changed is absent on the 4th and 5th press.
- bin1=2, bin2=3, then btn_clr_n and btn_inc1_n pressed in the same cycle -> both values 0 after the pulse; changed pulses once.
- btn_inc1_n and btn_inc2_n pressed in the same cycle from 1/1 -> both values become 2 on the same edge; a single changed pulse.
- btn_inc1_n held low, rst_n pulsed low for 3 cycles at cycle 5 of debounce -> bin1=0 during reset; after release bin1 becomes 1 exactly once, 7 cycles after rst_n rises.
